// File: rtl/uart_xmt_core.sv
// UART transmit engine: data register, frame shift register and serialiser (start, 8 data LSB first, stop).
// Optional even-parity bit between data and stop enabled by defining UART_XMT_PARITY_EN.
module uart_xmt_core #(
  parameter int unsigned WordSize     = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                bReset,
  input  logic [WordSize-1:0] InData,
  input  logic                Load_XMT_datareg,
  input  logic                Byte_ready,
  input  logic                T_byte,
  output logic                Serial_out,
  output logic                Busy,
  output logic                Frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(WordSize);
`ifdef UART_XMT_PARITY_EN
  localparam logic [3:0] STOP_IDX = 4'(WordSize + 2);
`else
  localparam logic [3:0] STOP_IDX = 4'(WordSize + 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SENDING = 2'd2
  } state_t;

  state_t              state;
  logic [WordSize-1:0] xmt_datareg;
  logic [WordSize-1:0] shift_reg;
  logic [BAUD_W-1:0]   baud_cnt;
  // Index of the bit currently on the line: 0 start, 1..WordSize data, then parity/stop.
  logic [3:0]          bit_cnt;
`ifdef UART_XMT_PARITY_EN
  logic                parity_bit;
`endif

  // Data register: loads in any state, independent of the frame in flight.
  always_ff @(posedge clk) begin
    if (bReset) begin
      xmt_datareg <= '0;
    end else if (Load_XMT_datareg) begin
      xmt_datareg <= InData;
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (bReset) begin
      state      <= IDLE;
      shift_reg  <= '1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      Serial_out <= 1'b1;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
`ifdef UART_XMT_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      Frame_done <= 1'b0;
      case (state)
        IDLE: begin
          Serial_out <= 1'b1;
          Busy       <= 1'b0;
          if (Byte_ready) begin
            shift_reg <= xmt_datareg;
`ifdef UART_XMT_PARITY_EN
            parity_bit <= ^xmt_datareg;
`endif
            state <= WAITING;
          end
        end
        WAITING: begin
          if (T_byte) begin
            state      <= SENDING;
            Serial_out <= 1'b0;
            Busy       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
          end
        end
        SENDING: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_IDX) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              Serial_out <= 1'b1;
              Busy       <= 1'b0;
              Frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt < DATA_LAST) begin
                Serial_out <= shift_reg[0];
                shift_reg  <= {1'b1, shift_reg[WordSize-1:1]};
`ifdef UART_XMT_PARITY_EN
              end else if (bit_cnt == DATA_LAST) begin
                Serial_out <= parity_bit;
`endif
              end else begin
                Serial_out <= 1'b1;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          Serial_out <= 1'b1;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmt_core.sv
// Directed bench for uart_xmt_core with hand-computed frame bit patterns (CLKS_PER_BIT = 4).
module tb_uart_xmt_core;

  localparam int unsigned CPB = 4;
`ifdef UART_XMT_PARITY_EN
  localparam int NB = 11;
  // Frame bits in line order, MSB first: start, d0..d7, parity, stop.
  localparam logic [10:0] F_A5 = 11'b0_10100101_0_1;
  localparam logic [10:0] F_FF = 11'b0_11111111_0_1;
  localparam logic [10:0] F_3C = 11'b0_00111100_0_1;
  localparam logic [10:0] F_81 = 11'b0_10000001_0_1;
  localparam logic [10:0] F_00 = 11'b0_00000000_0_1;
  localparam logic [10:0] F_07 = 11'b0_11100000_1_1;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = 11'b0_0_10100101_1;
  localparam logic [10:0] F_FF = 11'b0_0_11111111_1;
  localparam logic [10:0] F_3C = 11'b0_0_00111100_1;
  localparam logic [10:0] F_81 = 11'b0_0_10000001_1;
  localparam logic [10:0] F_00 = 11'b0_0_00000000_1;
  localparam logic [10:0] F_07 = 11'b0_0_11100000_1;
`endif

  logic       clk = 1'b0;
  logic       bReset;
  logic [7:0] InData;
  logic       Load_XMT_datareg;
  logic       Byte_ready;
  logic       T_byte;
  logic       Serial_out;
  logic       Busy;
  logic       Frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  uart_xmt_core #(.WordSize(8), .CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .bReset           (bReset),
    .InData           (InData),
    .Load_XMT_datareg (Load_XMT_datareg),
    .Byte_ready       (Byte_ready),
    .T_byte           (T_byte),
    .Serial_out       (Serial_out),
    .Busy             (Busy),
    .Frame_done       (Frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the start edge; checks every cycle of the frame and the done pulse.
  task automatic run_frame(input string tag, input logic [10:0] bits,
                           input int load_at, input logic [7:0] load_val);
    int done_seen;
    done_seen = 0;
    for (int i = 0; i < NB * int'(CPB); i++) begin
      n_tests++;
      assert (Serial_out === bits[NB - 1 - i / int'(CPB)] && Busy === 1'b1) else begin
        n_fail++;
        $error("FAIL %s_cycle%0d observed=so%b/busy%b expected=so%b/busy1", tag, i,
               Serial_out, Busy, bits[NB - 1 - i / int'(CPB)]);
      end
      if (Frame_done === 1'b1) done_seen++;
      if (i == load_at) begin
        InData = load_val;
        Load_XMT_datareg = 1'b1;
      end
      tick();
      Load_XMT_datareg = 1'b0;
    end
    chk({tag, "_early_done"}, 32'(done_seen), 32'd0);
    chk({tag, "_end_line"}, 32'(Serial_out), 32'd1);
    chk({tag, "_end_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(Frame_done), 32'd1);
    tick();
    chk({tag, "_done_clear"}, 32'(Frame_done), 32'd0);
  endtask

  task automatic load(input logic [7:0] d);
    InData = d;
    Load_XMT_datareg = 1'b1;
    tick();
    Load_XMT_datareg = 1'b0;
  endtask

  task automatic ready_and_start();
    Byte_ready = 1'b1;
    tick();
    Byte_ready = 1'b0;
    T_byte = 1'b1;
    tick();
    T_byte = 1'b0;
  endtask

  initial begin
    bReset = 1'b1;
    InData = 8'h00;
    Load_XMT_datareg = 1'b0;
    Byte_ready = 1'b0;
    T_byte = 1'b0;
    tick();
    tick();
    chk("rst_line", 32'(Serial_out), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Frame_done), 32'd0);
    bReset = 1'b0;

    // Basic A5 frame; WAITING holds the line idle until T_byte.
    load(8'hA5);
    Byte_ready = 1'b1;
    tick();
    Byte_ready = 1'b0;
    repeat (5) tick();
    chk("wait_line", 32'(Serial_out), 32'd1);
    chk("wait_busy", 32'(Busy), 32'd0);
    T_byte = 1'b1;
    tick();
    T_byte = 1'b0;
    run_frame("a5", F_A5, -1, 8'h00);

    // Load together with Byte_ready: frame takes the old register value.
    load(8'hFF);
    InData = 8'h3C;
    Load_XMT_datareg = 1'b1;
    Byte_ready = 1'b1;
    tick();
    Load_XMT_datareg = 1'b0;
    Byte_ready = 1'b0;
    T_byte = 1'b1;
    tick();
    T_byte = 1'b0;
    run_frame("old_ff", F_FF, -1, 8'h00);
    ready_and_start();
    run_frame("new_3c", F_3C, -1, 8'h00);

    // T_byte held from IDLE, Byte_ready arrives 3 cycles later.
    load(8'h81);
    T_byte = 1'b1;
    repeat (3) begin
      tick();
      chk("tidle_line", 32'(Serial_out), 32'd1);
    end
    Byte_ready = 1'b1;
    tick();
    Byte_ready = 1'b0;
    chk("tidle_br_line", 32'(Serial_out), 32'd1);
    chk("tidle_br_busy", 32'(Busy), 32'd0);
    tick();
    T_byte = 1'b0;
    // Mid-frame load of 00 must not disturb the 81 on the line.
    run_frame("f81_midload", F_81, 13, 8'h00);
    ready_and_start();
    run_frame("f00", F_00, -1, 8'h00);

    // Reset 13 cycles into a frame aborts it and clears the data register.
    load(8'hA5);
    ready_and_start();
    repeat (12) tick();
    chk("abort_pre_busy", 32'(Busy), 32'd1);
    bReset = 1'b1;
    tick();
    bReset = 1'b0;
    chk("abort_line", 32'(Serial_out), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Frame_done), 32'd0);
    T_byte = 1'b1;
    tick();
    chk("abort_idle_line", 32'(Serial_out), 32'd1);
    Byte_ready = 1'b1;
    tick();
    Byte_ready = 1'b0;
    tick();
    T_byte = 1'b0;
    run_frame("post_rst_00", F_00, -1, 8'h00);

    // Odd-parity data pattern.
    load(8'h07);
    ready_and_start();
    run_frame("f07", F_07, -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_xmt_core.md
Name: uart_xmt_core

Overview:
Serial transmit engine that consumes the three control strobes and data byte produced by the bus-side UART wrapper. It holds a data register, loads a frame shift register, and shifts an asynchronous frame out on Serial_out at a fixed clocks-per-bit rate. Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Sits between the bus wrapper and the off-chip TX pin.

Parameters:
WordSize, 8, data width in bits.
CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 1.

Ports:
clk  input  1  single clock; all logic on posedge.
bReset  input  1  synchronous reset, active-high: 1 = reset (this block only).
InData  input  WordSize  byte from wrapper.
Load_XMT_datareg  input  1  level; load InData into data register.
Byte_ready  input  1  level; move data register into frame shift register.
T_byte  input  1  level; start transmission of the loaded frame.
Serial_out  output  1  TX line; idles high.
Busy  output  1  high while a frame is on the line (SENDING state).
Frame_done  output  1  one-cycle pulse on the cycle after the stop bit ends.

Behaviour:
- Reset: state IDLE; XMT_datareg 0; shift register all 1s; baud counter 0; bit counter 0; Serial_out 1; Busy 0; Frame_done 0. Reset mid-frame aborts it: Serial_out is 1 after the reset edge, with no partial stop bit.
- Load_XMT_datareg: in any state, XMT_datareg <= InData at the sampling edge. It never affects the frame in flight.
- States: IDLE, WAITING, SENDING.
- IDLE: Byte_ready=1 -> shift register <= {XMT_datareg}; go to WAITING. Load_XMT_datareg and Byte_ready together: shift register gets the OLD XMT_datareg (register semantics). T_byte is ignored in IDLE, including when asserted in the same cycle as Byte_ready.
- WAITING: T_byte=1 -> go to SENDING; Serial_out <= 0 (start bit) on that edge; baud counter <= 0; bit counter <= 0. Byte_ready is ignored in WAITING. The block stays in WAITING indefinitely until T_byte.
- SENDING, bit timing: the baud counter counts 0..CLKS_PER_BIT-1. On the terminal count it wraps to 0, the bit counter increments, and the next bit is driven.
- SENDING, bit order: data bits LSB first (shift register shifts right, 1 shifted in), then the stop bit 1.
- SENDING, frame end: after the stop bit has lasted CLKS_PER_BIT cycles, return to IDLE with Serial_out=1 and Frame_done=1 for one cycle. Busy = (state==SENDING).
- Total frame: 10*CLKS_PER_BIT cycles from the start edge to the IDLE edge.
- Byte_ready and T_byte are ignored during SENDING. A wrapper holding them high afterward has no effect until IDLE/WAITING.
- Back-to-back frames: Byte_ready held high at the IDLE edge reloads immediately. The minimum inter-frame gap is 2 cycles: IDLE->WAITING, then WAITING->SENDING.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits, minimum 1. Bit counter is 4 bits. No other arithmetic.
- Serial_out is registered and glitch-free.

Optional Feature:
UART_XMT_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits, captured at Byte_ready) is sent after bit 7 and before the stop bit. The frame is 11*CLKS_PER_BIT cycles.
- Undefined: no parity bit; 10-bit frame as above.

Test Plan:
- Reset: bReset=1 for 2 cycles -> Serial_out=1, Busy=0, Frame_done=0. Reset asserted 13 cycles into a frame -> Serial_out=1 and state IDLE at the next edge.
- CLKS_PER_BIT=4, InData=8'hA5, Load, then Byte_ready, then T_byte -> Serial_out is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; Busy high 40 cycles; Frame_done pulses once.
- Load 8'h3C together with Byte_ready while XMT_datareg=8'hFF -> transmitted data is 8'hFF. The next Byte_ready/T_byte sends 8'h3C.
- T_byte held high from IDLE, with Byte_ready pulsed 3 cycles later -> no start bit before WAITING; start bit on the first edge in WAITING.
- Load 8'h00 mid-frame of 8'h81 -> line still shows 8'h81 bits. The next frame sends 8'h00 (all data bits 0, stop bit 1).
- With UART_XMT_PARITY_EN, send 8'hA5 -> parity bit 0 after bit 7, 44-cycle frame. Send 8'h07 -> parity bit 1.
